// File: rtl/prog_loader.sv
// prog_loader: streams a program into imem, runs the core until done, then drains dmem results.
// Optional LOADER_WDOG_EN: abort RUN with err after WDOG_CYCLES cycles without core_done.
module prog_loader #(
    parameter int IW          = 9,
    parameter int IADDR       = 8,
    parameter int DW          = 8,
    parameter int DADDR       = 8,
    parameter int RD_BASE     = 0,
    parameter int RD_LEN      = 4,
    parameter int CW          = 16,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [IW-1:0]    ld_data,
    input  logic             ld_last,
    output logic             im_we,
    output logic [IADDR-1:0] im_addr,
    output logic [IW-1:0]    im_wdata,
    output logic             core_rst,
    input  logic             core_done,
    output logic [DADDR-1:0] dm_addr,
    input  logic [DW-1:0]    dm_rdata,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DW-1:0]    res_data,
    output logic [CW-1:0]    cyc_cnt,
    output logic             busy,
    output logic             err
);
    typedef enum logic [2:0] {LOAD, RUN, FETCH, OFFER, HALT} state_t;
`ifdef LOADER_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif
    localparam logic [IADDR-1:0] WPTR_MAX  = {IADDR{1'b1}};
    localparam logic [CW-1:0]    CYC_MAX   = {CW{1'b1}};
    localparam logic [DADDR-1:0] RCNT_LAST = DADDR'(RD_LEN - 1);
    state_t           state;
    logic [IADDR-1:0] wptr;
    logic [DADDR-1:0] rcnt;
    assign ld_ready = state == LOAD;
    assign core_rst = state != RUN;
    assign busy     = state != HALT;
    assign im_we    = ld_valid & ld_ready;
    assign im_addr  = wptr;
    assign im_wdata = ld_data;
    assign dm_addr  = DADDR'(RD_BASE) + rcnt;
    // loader sequencer: program load, core run timing, result drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            wptr      <= '0;
            rcnt      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            cyc_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                LOAD: if (ld_valid) begin
                    if (wptr != WPTR_MAX) wptr <= wptr + 1'b1;
                    if (ld_last) begin
                        state   <= RUN;
                        cyc_cnt <= '0;
                    end else if (wptr == WPTR_MAX) begin
                        err   <= 1'b1;
                        state <= HALT;
                    end
                end
                RUN: if (core_done) state <= FETCH;
                else begin
                    cyc_cnt <= (cyc_cnt == CYC_MAX) ? cyc_cnt : cyc_cnt + 1'b1;
                    if (WDOG_ON && (32'(cyc_cnt) + 32'd1 >= 32'(WDOG_CYCLES))) begin
                        err   <= 1'b1;
                        state <= HALT;
                    end
                end
                FETCH: begin
                    res_data  <= dm_rdata;
                    res_valid <= 1'b1;
                    state     <= OFFER;
                end
                OFFER: if (res_ready) begin
                    res_valid <= 1'b0;
                    rcnt      <= rcnt + 1'b1;
                    state     <= (rcnt == RCNT_LAST) ? HALT : FETCH;
                end
                HALT: state <= HALT;
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed table-driven checks of prog_loader (load, run, drain, overflow, watchdog).
module tb_prog_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       ld_valid = 1'b0, ld_last = 1'b0, core_done = 1'b0, res_ready = 1'b0;
    logic [8:0] ld_data = '0;
    logic       ld_ready, im_we, core_rst, res_valid, busy, err;
    logic [7:0] im_addr, dm_addr, dm_rdata, res_data;
    logic [8:0] im_wdata;
    logic [15:0] cyc_cnt;

    assign dm_rdata = dm_addr * 8'd3;

    prog_loader #(.WDOG_CYCLES(20)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ld_last(ld_last), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .core_rst(core_rst), .core_done(core_done), .dm_addr(dm_addr), .dm_rdata(dm_rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .cyc_cnt(cyc_cnt),
        .busy(busy), .err(err)
    );

    logic       ld_valid2 = 1'b0, ld_last2 = 1'b0;
    logic [8:0] ld_data2 = '0;
    logic       ld_ready2, im_we2, core_rst2, res_valid2, busy2, err2;
    logic [1:0] im_addr2;
    logic [8:0] im_wdata2;
    logic [7:0] dm_addr2, res_data2;
    logic [15:0] cyc_cnt2;

    prog_loader #(.IADDR(2)) dut2 (
        .clk(clk), .reset(reset), .ld_valid(ld_valid2), .ld_ready(ld_ready2), .ld_data(ld_data2),
        .ld_last(ld_last2), .im_we(im_we2), .im_addr(im_addr2), .im_wdata(im_wdata2),
        .core_rst(core_rst2), .core_done(1'b0), .dm_addr(dm_addr2), .dm_rdata(8'h00),
        .res_valid(res_valid2), .res_ready(1'b0), .res_data(res_data2), .cyc_cnt(cyc_cnt2),
        .busy(busy2), .err(err2)
    );

    int tests = 0, fails = 0;
    logic saw_res_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ld_valid = 1'b0; ld_last = 1'b0; core_done = 1'b0; res_ready = 1'b0;
        ld_valid2 = 1'b0; ld_last2 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct { logic [8:0] data; logic last; logic [7:0] addr; } beat_t;
    typedef struct { logic [7:0] addr; logic [7:0] data; } res_t;
    beat_t beats[4];
    res_t  results[4];

    initial begin
        beats[0] = '{9'h1A0, 1'b0, 8'd0};
        beats[1] = '{9'h041, 1'b0, 8'd1};
        beats[2] = '{9'h0C2, 1'b0, 8'd2};
        beats[3] = '{9'h1FF, 1'b1, 8'd3};
        results[0] = '{8'd0, 8'd0};
        results[1] = '{8'd1, 8'd3};
        results[2] = '{8'd2, 8'd6};
        results[3] = '{8'd3, 8'd9};

        // reset values
        @(negedge clk); #1;
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_im_we", im_we, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_busy", busy, 1);
        chk("rst_err", err, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_cyc_cnt", cyc_cnt, 0);
        chk("rst_dm_addr", dm_addr, 0);
        chk("rst_res_data", res_data, 0);

        // T1: 3 beats then reset mid-beat
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_data = 9'(i + 5); ld_last = 1'b0;
            #1 chk("t1_addr", im_addr, i);
        end
        @(negedge clk);
        ld_data = 9'h077;
        #2 reset = 1'b1;
        #1 chk("t1_async_addr", im_addr, 0);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        chk("t1_ld_ready", ld_ready, 1);
        chk("t1_im_we", im_we, 0);
        chk("t1_core_rst", core_rst, 1);
        chk("t1_err", err, 0);
        reset = 1'b0;

        // T2: program load table, first beat after reset lands at address 0
        foreach (beats[i]) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_data = beats[i].data; ld_last = beats[i].last;
            #1;
            chk("t2_im_we", im_we, 1);
            chk("t2_im_addr", im_addr, beats[i].addr);
            chk("t2_im_wdata", im_wdata, beats[i].data);
            chk("t2_core_rst", core_rst, 1);
        end
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        chk("t2_run_core_rst", core_rst, 0);
        chk("t2_run_ld_ready", ld_ready, 0);
        chk("t2_run_im_we", im_we, 0);

        // T3: core_done first high in RUN cycle 11
        repeat (5) @(negedge clk);
        #1 chk("t3_mid_cyc", cyc_cnt, 5);
        repeat (5) @(negedge clk);
        core_done = 1'b1;
        #1;
        chk("t3_cyc_cnt", cyc_cnt, 10);
        chk("t3_core_rst_run", core_rst, 0);
        @(negedge clk);
        core_done = 1'b0;
        #1 chk("t3_core_frozen", core_rst, 1);
        foreach (results[i]) begin
            chk("t3_fetch_valid", res_valid, 0);
            chk("t3_dm_addr", dm_addr, results[i].addr);
            @(negedge clk); #1;
            chk("t3_offer_valid", res_valid, 1);
            chk("t3_res_data", res_data, results[i].data);
            @(negedge clk); #1;
            chk("t3_hold_valid", res_valid, 1);
            chk("t3_hold_data", res_data, results[i].data);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            #1;
        end
        chk("t3_halt_busy", busy, 0);
        chk("t3_halt_core_rst", core_rst, 1);
        chk("t3_halt_ld_ready", ld_ready, 0);
        chk("t3_halt_res_valid", res_valid, 0);
        chk("t3_halt_cyc_cnt", cyc_cnt, 10);
        chk("t3_halt_err", err, 0);
        ld_valid = 1'b1;
        #1 chk("t3_halt_im_we", im_we, 0);
        @(negedge clk); #1;
        chk("t3_halt_stays", busy, 0);

        // T6: watchdog (macro) or indefinite RUN (default)
        do_reset();
        @(negedge clk);
        ld_valid = 1'b1; ld_data = 9'h001; ld_last = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        saw_res_valid = 1'b0;
`ifdef LOADER_WDOG_EN
        repeat (20) @(negedge clk);
        #1;
        chk("t6_wdog_err", err, 1);
        chk("t6_wdog_busy", busy, 0);
        chk("t6_wdog_core_rst", core_rst, 1);
        chk("t6_wdog_cyc", cyc_cnt, 20);
        repeat (5) @(negedge clk);
        chk("t6_no_result", saw_res_valid, 0);
`else
        repeat (1000) @(negedge clk);
        #1;
        chk("t6_run_err", err, 0);
        chk("t6_run_busy", busy, 1);
        chk("t6_run_core_rst", core_rst, 0);
        chk("t6_run_cyc", cyc_cnt, 1000);
        chk("t6_no_result", saw_res_valid, 0);
`endif

        // T4: IADDR=2 overflow, four beats none last
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_valid2 = 1'b1; ld_data2 = 9'(i + 9'h100); ld_last2 = 1'b0;
            #1;
            chk("t4_im_we", im_we2, 1);
            chk("t4_im_addr", im_addr2, i);
            chk("t4_core_rst", core_rst2, 1);
        end
        @(negedge clk);
        ld_valid2 = 1'b0;
        #1;
        chk("t4_err", err2, 1);
        chk("t4_busy", busy2, 0);
        chk("t4_core_rst_halt", core_rst2, 1);
        chk("t4_ld_ready", ld_ready2, 0);

        // T5: IADDR=2, last on address 3
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_valid2 = 1'b1; ld_data2 = 9'(i); ld_last2 = (i == 3);
            #1 chk("t5_im_addr", im_addr2, i);
        end
        @(negedge clk);
        ld_valid2 = 1'b0; ld_last2 = 1'b0;
        #1;
        chk("t5_err", err2, 0);
        chk("t5_core_rst", core_rst2, 0);
        chk("t5_busy", busy2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    always @(posedge clk) if (res_valid && !reset && core_rst && busy && cyc_cnt != 10) saw_res_valid <= 1'b1;

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
